// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: fetches words over a req/ack port and queues {instr, npc} for decode.
// Optional performance counters (stall_cnt, flush_cnt) are built when IFQ_PERF_CNT_EN is defined.
module instr_fetch_queue #(
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_npc
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state;
  state_t            state_next;
  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] npc_mem   [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic              push;
  logic              pop;
  logic              can_fetch;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;

  assign out_valid = (count != '0);
  assign out_instr = instr_mem[head];
  assign out_npc   = npc_mem[head];

  // A redirect squashes both the returning word and any pop in the same cycle.
  always_comb begin
    push = (state == REQ) && imem_ack && !redirect;
    pop  = out_valid && out_ready && !redirect;
    if (redirect) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(push) - CNT_W'(pop);
    end
    can_fetch = !halt && (count_next < DEPTH_C);
    if (redirect) begin
      fetch_pc_next = redirect_pc;
    end else if (push) begin
      fetch_pc_next = fetch_pc + ADDR_W'(1);
    end else begin
      fetch_pc_next = fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = can_fetch ? REQ : IDLE;
      REQ: begin
        if (imem_ack) begin
          state_next = can_fetch ? REQ : IDLE;
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_next = can_fetch ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A fresh address is launched only when leaving IDLE or right after an ack; otherwise the request is held.
  always_comb begin
    req_d  = imem_req;
    addr_d = imem_addr;
    case (state_next)
      IDLE: begin
        req_d  = 1'b0;
        addr_d = fetch_pc_next;
      end
      REQ: begin
        req_d = 1'b1;
        if (state == IDLE || imem_ack) begin
          addr_d = fetch_pc_next;
        end
      end
      DROP: req_d = 1'b1;
      default: req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      imem_req  <= req_d;
      imem_addr <= addr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        npc_mem[i]   <= '0;
      end
    end else begin
      count    <= count_next;
      fetch_pc <= fetch_pc_next;
      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) begin
          instr_mem[tail] <= imem_rdata;
          npc_mem[tail]   <= imem_addr + ADDR_W'(1);
          tail            <= tail + PTR_W'(1);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
      end
    end
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_ready && !out_valid && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (redirect && flush_cnt != 16'hFFFF) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus random traffic against a
// transaction-level model (expected delivery PC, expected fetch PC, occupancy count).
module tb_instr_fetch_queue;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              halt = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_npc;
`ifdef IFQ_PERF_CNT_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  int                mcount;
  logic [ADDR_W-1:0] exp_pc;
  logic [ADDR_W-1:0] req_pc;
  bit                drop_pending;
  bit                prev_req, prev_ack, prev_halt, prev_redirect;
  logic [ADDR_W-1:0] prev_addr;
  int                waited;
  int                lat;
  bit                rand_lat;
  int                n_acks;
  bit                wrap_seen;
  bit                found;

  instr_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_npc     (out_npc)
`ifdef IFQ_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not terminate");
  end

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    return 32'(a) * 32'h0001_0001;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One clock cycle: memory responds, model is checked and updated, then the edge is taken.
  task automatic applyStimulus();
    logic [ADDR_W-1:0] nxt;
    imem_ack   = imem_req && (waited >= lat);
    imem_rdata = imem_ack ? word_of(imem_addr) : $urandom;

    checkOutput("out_valid", 32'(out_valid), 32'(mcount != 0));
    checkOutput("occupancy", 32'(mcount + int'(imem_req) <= DEPTH), 32'd1);
    if (prev_req && !prev_ack) begin
      checkOutput("req_hold", 32'(imem_req), 32'd1);
      checkOutput("addr_hold", 32'(imem_addr), 32'(prev_addr));
    end
    if (prev_halt && !prev_redirect && (!prev_req || prev_ack)) begin
      checkOutput("halt_noreq", 32'(imem_req), 32'd0);
    end

    if (out_valid && out_ready && !redirect) begin
      nxt = exp_pc + 1'b1;
      checkOutput("out_instr", out_instr, word_of(exp_pc));
      checkOutput("out_npc", 32'(out_npc), 32'(nxt));
      if (nxt == '0) wrap_seen = 1'b1;
      exp_pc = nxt;
      if (mcount > 0) mcount--;
    end

    if (imem_req && imem_ack) begin
      n_acks++;
      if (redirect || drop_pending) begin
        drop_pending = 1'b0;
      end else begin
        checkOutput("fetch_addr", 32'(imem_addr), 32'(req_pc));
        req_pc = req_pc + 1'b1;
        mcount++;
      end
    end

    if (redirect) begin
      if (imem_req && !imem_ack) drop_pending = 1'b1;
      mcount = 0;
      exp_pc = redirect_pc;
      req_pc = redirect_pc;
    end

    prev_req      = imem_req;
    prev_ack      = imem_ack;
    prev_halt     = halt;
    prev_redirect = redirect;
    prev_addr     = imem_addr;

    @(posedge clk);
    #1;
    if (prev_req && prev_ack) begin
      waited = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else if (prev_req) begin
      waited++;
    end
  endtask

  task automatic doReset();
    rst       = 1'b1;
    out_ready = 1'b0;
    halt      = 1'b0;
    redirect  = 1'b0;
    imem_ack  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_instr", out_instr, 32'd0);
    checkOutput("rst_npc", 32'(out_npc), 32'd0);
    mcount        = 0;
    exp_pc        = '0;
    req_pc        = '0;
    drop_pending  = 1'b0;
    prev_req      = 1'b0;
    prev_ack      = 1'b0;
    prev_halt     = 1'b0;
    prev_redirect = 1'b0;
    prev_addr     = '0;
    waited        = 0;
    n_acks        = 0;
    rst           = 1'b0;
  endtask

  initial begin
    rand_lat = 1'b0;
    lat      = 0;

    // Zero-wait streaming from reset.
    doReset();
    out_ready = 1'b1;
    applyStimulus();
    checkOutput("first_req", 32'(imem_req), 32'd1);
    checkOutput("first_addr", 32'(imem_addr), 32'd0);
    applyStimulus();
    checkOutput("first_valid", 32'(out_valid), 32'd1);
    checkOutput("first_instr", out_instr, 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
    end

    // Decode stalled: queue fills to DEPTH then fetch stops.
    doReset();
    repeat (8) applyStimulus();
    checkOutput("full_req_off", 32'(imem_req), 32'd0);
    checkOutput("full_acks", 32'(n_acks), 32'd4);
    out_ready = 1'b1;
    repeat (8) applyStimulus();

    // Slow memory, redirect while addr 5 is outstanding.
    doReset();
    out_ready = 1'b1;
    lat       = 3;
    found     = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (imem_req && imem_addr == 10'd5 && waited == 0) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("reach_addr5", 32'(found), 32'd1);
    applyStimulus();
    redirect    = 1'b1;
    redirect_pc = 10'h200;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("drop_req", 32'(imem_req), 32'd1);
    checkOutput("drop_addr", 32'(imem_addr), 32'd5);
    for (int i = 0; i < 40 && !out_valid; i++) applyStimulus();
    checkOutput("tgt_valid", 32'(out_valid), 32'd1);
    checkOutput("tgt_npc", 32'(out_npc), 32'h201);
    applyStimulus();

    // Redirect coincident with ack and pop.
    lat = 0;
    repeat (6) applyStimulus();
    checkOutput("steady_valid", 32'(out_valid), 32'd1);
    checkOutput("steady_req", 32'(imem_req), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 10'h123;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("redir_addr", 32'(imem_addr), 32'h123);
    checkOutput("redir_req", 32'(imem_req), 32'd1);
    checkOutput("redir_flush", 32'(out_valid), 32'd0);
    repeat (4) applyStimulus();

    // Address wrap at the top of memory.
    redirect    = 1'b1;
    redirect_pc = 10'h3FE;
    applyStimulus();
    redirect  = 1'b0;
    wrap_seen = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("wrap_seen", 32'(wrap_seen), 32'd1);

    // Halt mid-request: pending word delivered, then no requests until release.
    lat   = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && waited == 1) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("reach_midreq", 32'(found), 32'd1);
    halt = 1'b1;
    repeat (10) applyStimulus();
    checkOutput("halt_idle", 32'(imem_req), 32'd0);
    checkOutput("halt_drained", 32'(out_valid), 32'd0);
    halt = 1'b0;
    repeat (10) applyStimulus();

    // Random traffic.
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom % 4) != 0;
      if (($urandom % 24) == 0) halt = !halt;
      redirect    = !halt && (($urandom % 32) == 0);
      redirect_pc = ADDR_W'($urandom);
      applyStimulus();
    end
    redirect = 1'b0;
    halt     = 1'b0;
    rand_lat = 1'b0;

    // Asynchronous reset in the middle of a handshake.
    lat   = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && waited == 1) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("reach_async", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_req", 32'(imem_req), 32'd0);
    checkOutput("async_addr", 32'(imem_addr), 32'd0);
    checkOutput("async_valid", 32'(out_valid), 32'd0);
    doReset();
    lat       = 0;
    out_ready = 1'b1;
    repeat (10) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front-end that sits directly upstream of the pipeline's IF/ID register. It fetches 32-bit instruction words from an external word-addressed instruction memory over a req/ack handshake and buffers them with their next-PC in a small FIFO. It hands them to decode over a valid/ready interface. A taken branch redirects it: the queue is flushed and fetch restarts at the target.

## Interface
- ADDR_W, 10, instruction address width in words (matches the 1024-word memory)
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request, registered
- imem_addr  out  ADDR_W  word address, stable while imem_req=1
- imem_ack  in  1  request accepted; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  taken-branch pulse; overrides everything else
- redirect_pc  in  ADDR_W  branch target
- halt  in  1  level; blocks new requests
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_instr  out  32  head instruction
- out_npc  out  ADDR_W  head address + 1

## Operation
- State: fetch_pc, FIFO (DEPTH × {instr, npc}), count (0..DEPTH), FSM {IDLE, REQ, DROP}.
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_npc=0, count=0, FSM=IDLE, fetch_pc=RESET_PC.
- IDLE: if !halt and count_next < DEPTH, go to REQ. Set imem_req=1 and imem_addr=fetch_pc.
- REQ: hold imem_req/imem_addr until imem_ack. On ack:
  - push {imem_rdata, imem_addr+1}.
  - fetch_pc += 1, modulo 2^ADDR_W. Address 2^ADDR_W−1 wraps to 0, and its npc is 0.
  - If !halt and count_next < DEPTH, stay in REQ with the new address (no bubble). Otherwise go to IDLE and drop imem_req.
- There is at most one outstanding request. Occupancy is at most DEPTH, counting the in-flight word.
- Pop: out_valid && out_ready advances the head. Push and pop in the same cycle leave count unchanged. A push into a full queue cannot occur by construction.
- Redirect (priority over push, pop and halt):
  - count←0 and out_valid←0 on the next edge.
  - fetch_pc←redirect_pc.
  - If a request is in flight without imem_ack this cycle, go to DROP. In DROP, imem_req stays high with the old address until ack, the returned word is discarded, then the FSM goes to IDLE/REQ at the new PC.
  - If imem_ack coincides with redirect, discard that word and issue the new request at redirect_pc on the next cycle.
  - A redirect while in DROP updates fetch_pc only.
- halt: no new requests. An in-flight request completes and pushes. The queue keeps draining.
- count_next = count + push − pop (0 after redirect).

## Timing
- The first imem_req rises on the first posedge after rst deasserts.
- Fetch latency: ack at edge N → entry visible as out_valid/out_instr after edge N (1 cycle when the queue is empty).
- Zero-wait memory (ack same cycle as req) sustains 1 instruction/cycle while out_ready=1.
- Redirect at edge N:
  - queue empty after N.
  - imem_addr=redirect_pc after N if idle or if ack coincided.
  - the first target instruction is on out_* no earlier than edge N+2.
- Asserting rst mid-handshake immediately forces the reset values. The memory side must tolerate an abandoned request.
- Outputs out_instr/out_npc are driven from the FIFO head register. They are undefined-but-stable when out_valid=0, and 0 after reset.

## Configuration
- IFQ_PERF_CNT_EN defined:
  - adds ports stall_cnt (out, 16) and flush_cnt (out, 16), both reset to 0 and saturating at 0xFFFF.
  - stall_cnt increments each cycle out_ready=1 && out_valid=0.
  - flush_cnt increments per redirect cycle.
- Undefined: these ports and their counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset release, zero-wait memory returning word=addr·0x10001, out_ready=1:
  - imem_addr sequence 0,1,2,…
  - out_instr 0x00000000, 0x00010001, … with out_npc 1,2,…
  - one per cycle after a 2-cycle startup.
- out_ready=0 with zero-wait memory: exactly DEPTH=4 words fetched (addr 0–3), then imem_req=0. Raising out_ready resumes at addr 4 with no loss or duplication.
- Memory with 3-cycle ack and redirect to 0x200 one cycle after req for addr 5:
  - req stays on addr 5 until ack, and that word is never output.
  - the next request is 0x200.
  - out_npc of the first output = 0x201.
- Redirect coincident with imem_ack and pop: queue flushed, coincident word dropped, next imem_addr=redirect_pc.
- fetch_pc=0x3FF: the word is output with out_npc=0, and the next request is addr 0.
- halt asserted mid-request: the pending word is delivered and no further imem_req appears. halt deassert resumes at the next sequential address.
